// File: rtl/clock_div_gen.sv
// clock_div_gen: multi-channel clock divider / strobe generator with runtime ratios.
// A new ratio is applied only at terminal count or SYNC, so the outputs never glitch.
module clock_div_gen #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [CH_W-1:0]  i_wr_ch,
  input  logic [DIV_W-1:0] i_wr_div,
  input  logic             i_sync,
  output logic [N_CH-1:0]  o_busy,
  output logic [N_CH-1:0]  o_stb,
  output logic [N_CH-1:0]  o_div_clk
);
  logic w_wr_ok;
  assign w_wr_ok = i_wr_en && ({1'b0, i_wr_ch} < (CH_W + 1)'(N_CH));
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DIV_W-1:0] r_cnt, r_div, r_pend;
    logic r_busy, r_stb, r_dclk;
    logic w_tc, w_apply, w_sel;
    always_comb begin
      w_tc    = (r_div != '0) && (r_cnt == r_div - 1'b1);
      w_apply = i_sync || w_tc || (r_div == '0);
      w_sel   = w_wr_ok && (i_wr_ch == CH_W'(c));
    end
    // Outputs are registered from the current count, so they trail r_cnt by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt  <= '0;
        r_div  <= DIV_W'(DEFAULT_DIV);
        r_pend <= '0;
        r_busy <= 1'b0;
        r_stb  <= 1'b0;
        r_dclk <= 1'b0;
      end else begin
        r_cnt  <= w_apply ? '0 : r_cnt + 1'b1;
        r_div  <= (w_apply && r_busy) ? r_pend : r_div;
        r_pend <= w_sel ? i_wr_div : r_pend;
        r_busy <= w_sel || (r_busy && !w_apply);
        r_stb  <= w_tc;
        r_dclk <= r_cnt < (r_div >> 1);
      end
    end
    assign o_busy[c]    = r_busy;
    assign o_stb[c]     = r_stb;
    assign o_div_clk[c] = r_dclk;
  end
endmodule
